dog_extreme_detect: RTL and testbench

- Streaming 3x3x3 local-extremum detector for the SIFT keypoint stage.
- Inputs: three co-registered DoG layers (below, centre, above) arriving one pixel per accepted beat in raster order.
- Owns its own line buffers and window registers, and applies a contrast threshold.
- Emits one verdict (max / min / none) per interior centre pixel, with coordinates, to the downstream keypoint refinement.

---
 rtl/sift_pkg.sv | 19 +
 rtl/dog_line_window.sv | 47 ++++
 rtl/dog_extreme_detect.sv | 157 +++++++++++++++
 tb/tb_dog_extreme_detect.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared SIFT types and defaults: DoG sample width, verdict record, contrast threshold.
package sift_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int THRESH_DEF = 3;
   localparam int X_W_DEF    = 10;
   localparam int Y_W_DEF    = 9;

   typedef logic signed [DATA_W_DEF-1:0] sample_t;

   typedef struct packed {
      logic                 is_max;
      logic                 is_min;
      sample_t              centre;
      logic [X_W_DEF-1:0]   x;
      logic [Y_W_DEF-1:0]   y;
   } verdict_t;

endpackage

// File: rtl/dog_line_window.sv
// One DoG layer: two line buffers feeding a 3x3 shift window; win[r][c], r=0 newest row, c=0 newest column.
module dog_line_window
   import sift_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 640,
   parameter int X_W    = X_W_DEF
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic [X_W-1:0]                   col,
   input  logic [DATA_W-1:0]                din,
   output logic [2:0][2:0][DATA_W-1:0]      win
);

   // lb0 holds the previous line, lb1 the one before; contents are never reset.
   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] up1;
   logic [DATA_W-1:0] up2;

   assign up1 = lb0[col];
   assign up2 = lb1[col];

   always_ff @(posedge clk) begin
      if (en) begin
         lb0[col] <= din;
         lb1[col] <= up1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win <= '0;
      end else if (en) begin
         for (int r = 0; r < 3; r++) begin
            win[r][2] <= win[r][1];
            win[r][1] <= win[r][0];
         end
         win[0][0] <= din;
         win[1][0] <= up1;
         win[2][0] <= up2;
      end
   end

endmodule

// File: rtl/dog_extreme_detect.sv
// Streaming 3x3x3 DoG local-extremum detector with contrast threshold and raster coordinates.
// Optional macro DOG_EXTREME_BORDER_EN adds a BORDER-pixel suppression band on every edge.
module dog_extreme_detect
   import sift_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int THRESH = THRESH_DEF,
   parameter int X_W    = X_W_DEF,
   parameter int Y_W    = Y_W_DEF
`ifdef DOG_EXTREME_BORDER_EN
   ,parameter int BORDER = 4
`endif
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sof,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] diff0,
   input  logic signed [DATA_W-1:0] diff1,
   input  logic signed [DATA_W-1:0] diff2,
   output logic                     out_valid,
   output logic                     is_max,
   output logic                     is_min,
   output logic signed [DATA_W-1:0] centre,
   output logic [X_W-1:0]           out_x,
   output logic [Y_W-1:0]           out_y,
   output logic                     frame_err
);

   localparam int STAGES = 3;

   logic [X_W-1:0] col, pcol;
   logic [Y_W-1:0] row, prow;
   logic           last_col, last_row, emit;

   // sof overrides the running position for its own beat.
   assign pcol     = sof ? '0 : col;
   assign prow     = sof ? '0 : row;
   assign last_col = (pcol == X_W'(IMG_W - 1));
   assign last_row = (prow == Y_W'(IMG_H - 1));
   assign emit     = in_valid && (pcol >= X_W'(2)) && (prow >= Y_W'(2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col       <= '0;
         row       <= '0;
         frame_err <= 1'b0;
      end else if (in_valid) begin
         if (sof && (col != '0 || row != '0))
            frame_err <= 1'b1;
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : prow + Y_W'(1);
         end else begin
            col <= pcol + X_W'(1);
            row <= prow;
         end
      end
   end

   logic [2:0][DATA_W-1:0]            din;
   logic [2:0][2:0][2:0][DATA_W-1:0]  win;

   assign din[0] = diff0;
   assign din[1] = diff1;
   assign din[2] = diff2;

   for (genvar g = 0; g < 3; g++) begin : g_layer
      dog_line_window #(
         .DATA_W (DATA_W),
         .IMG_W  (IMG_W),
         .X_W    (X_W)
      ) u_lw (
         .clk (clk),
         .rst (rst),
         .en  (in_valid),
         .col (pcol),
         .din (din[g]),
         .win (win[g])
      );
   end

   // Pipeline: vld_pipe[0] window loaded, [1] S1 samples, [2] S2 flags, [3] outputs.
   logic [STAGES:0]                   vld_pipe;
   logic [X_W-1:0]                    x0, s1_x, s2_x;
   logic [Y_W-1:0]                    y0, s1_y, s2_y;
   logic [2:0][2:0][2:0][DATA_W-1:0]  s1_win;
   logic signed [DATA_W-1:0]          c_s1, s2_c;
   logic [26:0]                       gt_c, lt_c, s2_gt, s2_lt;
   logic [DATA_W:0]                   c_ext, mag;
   logic                              thr_c, s2_thr, s2_brd;

   // Centre slot is forced to 1 so a plain AND-reduce covers the 26 neighbours.
   always_comb begin
      c_s1 = $signed(s1_win[1][1][1]);
      gt_c = '1;
      lt_c = '1;
      for (int l = 0; l < 3; l++)
         for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
               if (!(l == 1 && r == 1 && k == 1)) begin
                  gt_c[l*9 + r*3 + k] = c_s1 > $signed(s1_win[l][r][k]);
                  lt_c[l*9 + r*3 + k] = c_s1 < $signed(s1_win[l][r][k]);
               end
      // One extra bit keeps |most-negative| representable.
      c_ext = {c_s1[DATA_W-1], c_s1};
      mag   = c_ext[DATA_W] ? (~c_ext + 1'b1) : c_ext;
      thr_c = mag >= (DATA_W+1)'(THRESH);
   end

   always_ff @(posedge clk) begin
      if (emit) begin
         x0 <= pcol - X_W'(1);
         y0 <= prow - Y_W'(1);
      end
      s1_win <= win;
      s1_x   <= x0;
      s1_y   <= y0;
      s2_gt  <= gt_c;
      s2_lt  <= lt_c;
      s2_thr <= thr_c;
      s2_c   <= c_s1;
      s2_x   <= s1_x;
      s2_y   <= s1_y;
`ifdef DOG_EXTREME_BORDER_EN
      s2_brd <= (int'(s1_x) >= BORDER) && (int'(s1_x) < IMG_W - BORDER) &&
                (int'(s1_y) >= BORDER) && (int'(s1_y) < IMG_H - BORDER);
`endif
   end

`ifndef DOG_EXTREME_BORDER_EN
   assign s2_brd = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         is_max   <= 1'b0;
         is_min   <= 1'b0;
         centre   <= '0;
         out_x    <= '0;
         out_y    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], emit};
         is_max   <= vld_pipe[2] & (&s2_gt) & s2_thr & s2_brd;
         is_min   <= vld_pipe[2] & (&s2_lt) & s2_thr & s2_brd;
         centre   <= vld_pipe[2] ? s2_c : '0;
         out_x    <= vld_pipe[2] ? s2_x : '0;
         out_y    <= vld_pipe[2] ? s2_y : '0;
      end
   end

   assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_dog_extreme_detect.sv
// Directed bench for dog_extreme_detect on an 8x6 frame: golden verdict lists, latency, sof/reset handling.
module tb_dog_extreme_detect;

   localparam int DW = 8, IW = 8, IH = 6, TH = 3, XW = 3, YW = 3;

   logic clk = 1'b0, rst = 1'b1, sof = 1'b0, in_valid = 1'b0;
   logic signed [DW-1:0] diff0 = '0, diff1 = '0, diff2 = '0;
   logic                 out_valid, is_max, is_min, frame_err;
   logic signed [DW-1:0] centre;
   logic [XW-1:0]        out_x;
   logic [YW-1:0]        out_y;

   int n_chk = 0, n_pass = 0, cyc = 0, beat_cyc = 0, bad_idle = 0, mode = 0;

   typedef struct { int x; int y; int c; int mx; int mn; int t; } vrd_t;
   vrd_t got_q[$];
   vrd_t exp_q[$];
   vrd_t mon_v;

   dog_extreme_detect #(
      .DATA_W (DW), .IMG_W (IW), .IMG_H (IH), .THRESH (TH), .X_W (XW), .Y_W (YW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sof       (sof),
      .in_valid  (in_valid),
      .diff0     (diff0),
      .diff1     (diff1),
      .diff2     (diff2),
      .out_valid (out_valid),
      .is_max    (is_max),
      .is_min    (is_min),
      .centre    (centre),
      .out_x     (out_x),
      .out_y     (out_y),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) begin
         mon_v.x  = int'(out_x);
         mon_v.y  = int'(out_y);
         mon_v.c  = int'(centre);
         mon_v.mx = int'(is_max);
         mon_v.mn = int'(is_min);
         mon_v.t  = cyc;
         got_q.push_back(mon_v);
         if (is_max && is_min) bad_idle++;
      end else if (is_max || is_min || centre != '0) begin
         bad_idle++;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int pix(input int l, input int x, input int y);
      int base;
      base = (mode == 1 || mode == 4) ? 10 : 0;
      if (l == 1 && x == 3 && y == 2) begin
         case (mode)
            1, 4: return 50;
            2:    return -128;
            3:    return 2;
            default: return base;
         endcase
      end
      if (l == 2 && x == 3 && y == 2 && mode == 4) return 50;
      return base;
   endfunction

   function automatic int pack(input vrd_t v);
      return (v.x << 20) | (v.y << 16) | ((v.c & 255) << 8) | (v.mx << 1) | v.mn;
   endfunction

   task automatic build_exp();
      vrd_t v;
      int   c, n;
      exp_q.delete();
      for (int y = 1; y < IH - 1; y++)
         for (int x = 1; x < IW - 1; x++) begin
            c = pix(1, x, y);
            v.x = x; v.y = y; v.c = c; v.mx = 1; v.mn = 1; v.t = 0;
            for (int l = 0; l < 3; l++)
               for (int dy = -1; dy <= 1; dy++)
                  for (int dx = -1; dx <= 1; dx++)
                     if (!(l == 1 && dx == 0 && dy == 0)) begin
                        n = pix(l, x + dx, y + dy);
                        if (!(c > n)) v.mx = 0;
                        if (!(c < n)) v.mn = 0;
                     end
            if ((c < 0 ? -c : c) < TH) begin v.mx = 0; v.mn = 0; end
            exp_q.push_back(v);
         end
   endtask

   task automatic cmp_frame(input string tag);
      build_exp();
      chk({tag, "_count"}, got_q.size(), (IW - 2) * (IH - 2));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_v%0d", tag, i), pack(got_q[i]), pack(exp_q[i]));
      got_q.delete();
   endtask

   // Returns the number of extremum verdicts in the capture and the index of the last one.
   task automatic find_ext(output int n, output int idx);
      n = 0; idx = 0;
      foreach (got_q[i]) if (got_q[i].mx || got_q[i].mn) begin n++; idx = i; end
   endtask

   task automatic send_beat(input int x, input int y, input bit s);
      @(negedge clk);
      in_valid = 1'b1;
      sof      = s;
      diff0    = DW'(pix(0, x, y));
      diff1    = DW'(pix(1, x, y));
      diff2    = DW'(pix(2, x, y));
      if (x == 4 && y == 3) beat_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         sof      = 1'b0;
      end
   endtask

   task automatic run_frame(input bit gap);
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++) begin
            send_beat(x, y, (x == 0 && y == 0));
            if (gap) idle(1);
         end
      idle(6);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, idx;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_is_max",    int'(is_max),    0);
      chk("rst_centre",    int'(centre),    0);
      chk("rst_frame_err", int'(frame_err), 0);
      rst = 1'b1;

      mode = 0; run_frame(0);
      cmp_frame("zero");

      mode = 1; run_frame(0);
      find_ext(n, idx);
      chk("peak_n", n, 1);
      if (n > 0) begin
         chk("peak_x",   got_q[idx].x,  3);
         chk("peak_y",   got_q[idx].y,  2);
         chk("peak_c",   got_q[idx].c,  50);
         chk("peak_max", got_q[idx].mx, 1);
         chk("peak_lat", got_q[idx].t - beat_cyc, 4);
      end
      cmp_frame("peak");

      mode = 2; run_frame(0);
      find_ext(n, idx);
      chk("neg_n", n, 1);
      if (n > 0) begin
         chk("neg_min", got_q[idx].mn, 1);
         chk("neg_c",   got_q[idx].c,  -128);
      end
      cmp_frame("neg");

      mode = 3; run_frame(0);
      find_ext(n, idx);
      chk("thr_n", n, 0);
      cmp_frame("thr");

      mode = 4; run_frame(0);
      find_ext(n, idx);
      chk("tie_n", n, 0);
      cmp_frame("tie");

      mode = 1; run_frame(1);
      find_ext(n, idx);
      chk("gap_n", n, 1);
      if (n > 0) chk("gap_lat", got_q[idx].t - beat_cyc, 4);
      cmp_frame("gap");

      chk("ferr_pre", int'(frame_err), 0);
      for (int p = 0; p < 2 * IW + 5; p++) send_beat(p % IW, p / IW, p == 0);
      idle(6);
      got_q.delete();
      run_frame(0);
      chk("ferr_set", int'(frame_err), 1);
      cmp_frame("resync");

      for (int p = 0; p < 3 * IW + 6; p++) send_beat(p % IW, p / IW, p == 0);
      @(posedge clk); #1;
      chk("pre_rst_valid", int'(out_valid), 1);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_centre",    int'(centre),    0);
      chk("arst_out_x",     int'(out_x),     0);
      chk("arst_frame_err", int'(frame_err), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      got_q.delete();
      run_frame(0);
      cmp_frame("post_rst");

      chk("idle_zero", bad_idle, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
